if_fetch_unit: RTL

Parametrised instruction-fetch stage for the pipelined RV32I core, replacing the bare PC register in front of the IF/ID boundary. Drives the instruction-memory word address and captures the one-cycle-latency read data into a DEPTH-entry prefetch queue. Hands {pc, instr} pairs to decode over a valid/ready handshake. Accepts branch/jump redirects from EXE, which flush all queued and in-flight fetches.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/if_fetch_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: default widths, reset PC and the fetch payload.
package cpu_pkg;

    localparam int unsigned DEF_PC_W     = 14;
    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef struct packed {
        logic [DEF_PC_W-1:0] pc;
        logic [DEF_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with synchronous flush and combinational head read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers and occupancy; flush overrides any concurrent push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-based IM issue, single in-flight tracker and
// a prefetch queue handing {pc, instr} to decode; EXE redirects flush everything.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = DEF_PC_W,
    parameter int unsigned     XLEN     = DEF_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [PC_W-1:0]            im_addr,
    output logic                       im_req,
    input  logic [XLEN-1:0]            im_rdata,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_instr,
    output logic [PC_W-1:0]            id_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_level
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = PC_W + XLEN;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;
    logic            queue_empty;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     credit_used;

    // Slots already spoken for: queued entries plus the outstanding response,
    // minus the one leaving this cycle. Issuing only below DEPTH guarantees room.
    assign pop         = id_valid && id_ready;
    assign credit_used = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue       = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign push        = inflight && !redirect_valid;

    assign im_req   = issue;
    assign im_addr  = fetch_pc;
    assign id_valid = !queue_empty;
    assign id_pc    = head[EW-1:XLEN];
    assign id_instr = head[XLEN-1:0];
    assign q_level  = count;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({inflight_pc, im_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .empty (queue_empty)
    );

    // Fetch PC and in-flight tracker; a redirect drops the arriving response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_W'(1);
            end
        end
    end

endmodule
